// File: rtl/fft_result_reader_pkg.sv
// Shared constants, state encoding and the A-law expansion used by the spectrum read-back path.
// The encoder side uses the same segment/mantissa split.
package fft_result_reader_pkg;

    localparam int LENGTH     = 256;
    localparam int ADDR_W     = 8;
    localparam int CODE_W     = 8;
    localparam int DATA_OUT_W = 15;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = ADDR_W + 1;

    localparam int SEG_W  = 3;
    localparam int MANT_W = 5;
    localparam int LIN_W  = 15;
    localparam int SHIFT0 = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic             last;
        logic [LIN_W-1:0] mag;
    } fifo_entry_t;

    // Segment 0 is linear with a half-step offset; higher segments add the implied leading one.
    function automatic logic [LIN_W-1:0] alaw_expand(input logic [CODE_W-1:0] code);
        logic [SEG_W-1:0]  seg;
        logic [MANT_W-1:0] mant;
        logic [LIN_W-1:0]  base;
        logic [3:0]        sh;
        seg  = code[CODE_W-1:MANT_W];
        mant = code[MANT_W-1:0];
        if (seg == '0) begin
            return (LIN_W'(mant) << SHIFT0) + LIN_W'(4);
        end
        base = LIN_W'({1'b1, mant});
        sh   = 4'(seg) + 4'(SHIFT0 - 1);
        return (base << sh) + (LIN_W'(1) << (sh - 4'd1));
    endfunction

endpackage

// File: rtl/fft_result_reader_alaw_decoder.sv
// Registered A-law to linear magnitude expander, one cycle of latency.
module alaw_decoder
    import fft_result_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] data_in,
    input  logic              valid_in,
    output logic [LIN_W-1:0]  data_out,
    output logic              valid_out
);

    logic [LIN_W-1:0] data_q;
    logic [LIN_W-1:0] data_d;
    logic             valid_q;

    always_comb begin
        data_d = data_q;
        if (valid_in) begin
            data_d = alaw_expand(data_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_in;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fft_result_reader.sv
// Streams the stored A-law spectrum out as linear magnitudes over valid/ready.
// Reads are credit-limited so the small show-ahead FIFO can never overflow.
module fft_result_reader
    import fft_result_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              work,
    output logic              finish,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [1:0]        in_flight_q, in_flight_d;
    logic [PTR_W:0]    fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              rd_pend_q;
    fifo_entry_t       fifo_q [FIFO_DEPTH];

    logic              start_acc;
    logic              push;
    logic              pop;
    logic [PTR_W+1:0]  credit_sum;
    logic [LIN_W-1:0]  dec_mag;
    fifo_entry_t       head;
    fifo_entry_t       push_entry;
    logic              unused_hi;

    // Upper byte of the RAM word carries unrelated data.
    assign unused_hi = ^mem_data[15:8];

    alaw_decoder u_decoder (
        .clk       (clk),
        .reset     (reset),
        .data_in   (mem_data[CODE_W-1:0]),
        .valid_in  (rd_pend_q),
        .data_out  (dec_mag),
        .valid_out (push)
    );

    assign head       = fifo_q[rd_ptr_q];
    assign start_acc  = (state_q == IDLE) && start;
    assign pop        = out_valid && out_ready;
    assign credit_sum = (PTR_W+2)'(in_flight_q) + (PTR_W+2)'(fifo_count_q);
    assign mem_addr   = rd_cnt_q[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (mem_rd && rd_cnt_q == CNT_W'(LENGTH - 1)) state_d = DRAIN;
            DRAIN:   if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work      = (state_q != IDLE);
        mem_rd    = (state_q == READ) && (credit_sum < (PTR_W+2)'(FIFO_DEPTH));
        out_valid = (fifo_count_q != '0);
        out_data  = out_valid ? {{(16-LIN_W){1'b0}}, head.mag} : 16'd0;
        out_last  = out_valid && head.last;
        finish    = (state_q == DRAIN) && pop && head.last;
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (start_acc) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else begin
            if (mem_rd) rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (push)   wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        in_flight_d  = in_flight_q + 2'(mem_rd) - 2'(push);
        fifo_count_d = fifo_count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            in_flight_q  <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_pend_q    <= 1'b0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            in_flight_q  <= in_flight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_pend_q    <= mem_rd;
        end
    end

    // The last flag is attached at write time so it stays aligned with its word through stalls.
    always_comb begin
        push_entry.last = (wr_cnt_q == CNT_W'(LENGTH - 1));
        push_entry.mag  = dec_mag;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule
